// File: rtl/microc_pkg.sv
// Shared microcontroller definitions: default datapath widths and the
// sign-magnitude decoder used by the PC sequencer and the ALU immediate path.
package microc_pkg;

    localparam int PC_WIDTH_DEF  = 10;
    localparam int OFF_WIDTH_DEF = 10;
    localparam int DEPTH_DEF     = 8;

    // Bit width-1 of raw is the sign and the lower bits are the magnitude.
    // Negative zero decodes to 0. The caller truncates the result to its own width.
    function automatic logic signed [31:0] sm_decode(input logic [31:0] raw, input int width);
        logic [31:0]        mask;
        logic signed [31:0] mag;
        mask = (32'd1 << (width - 1)) - 32'd1;
        mag  = signed'(raw & mask);
        return raw[width-1] ? -mag : mag;
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Bundle between the instruction decoder (master) and the PC sequencer (slave).
interface pc_sequencer_if
    import microc_pkg::*;
#(
    parameter int PC_WIDTH  = PC_WIDTH_DEF,
    parameter int OFF_WIDTH = OFF_WIDTH_DEF,
    parameter int DEPTH     = DEPTH_DEF
);
    logic                       hold;
    logic                       s_inc;
    logic                       s_rel;
    logic                       s_call;
    logic                       s_ret;
    logic                       clear_err;
    logic [PC_WIDTH-1:0]        target;
    logic [OFF_WIDTH-1:0]       offset;
    logic [PC_WIDTH-1:0]        pc_out;
    logic [$clog2(DEPTH):0]     depth_out;
    logic                       overflow;
    logic                       underflow;

    modport master (
        output hold, s_inc, s_rel, s_call, s_ret, clear_err, target, offset,
        input  pc_out, depth_out, overflow, underflow
    );

    modport slave (
        input  hold, s_inc, s_rel, s_call, s_ret, clear_err, target, offset,
        output pc_out, depth_out, overflow, underflow
    );
endinterface

// File: rtl/pc_sequencer_stack.sv
// Return-address LIFO: register array with depth as the write pointer and an
// asynchronous read of the top entry so a return completes in one cycle.
module return_stack #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic [$clog2(DEPTH):0] depth,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int DW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [DW-1:0]    depth_q;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    top_ptr;

    assign wr_ptr  = depth_q[AW-1:0];
    assign top_ptr = AW'(depth_q - DW'(1));
    assign full    = (depth_q == DW'(DEPTH));
    assign empty   = (depth_q == '0);
    assign dout    = mem_q[top_ptr];
    assign depth   = depth_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            depth_q <= '0;
        end else if (push && !full) begin
            depth_q <= depth_q + DW'(1);
        end else if (pop && !empty) begin
            depth_q <= depth_q - DW'(1);
        end
    end

    // Stack contents are never reset; only the pointer decides what is valid.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem_q[wr_ptr] <= din;
        end
    end
endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: next-PC selection (ret > call > jump/inc/rel),
// return-address stack and sticky stack-error flags.
module pc_sequencer
    import microc_pkg::*;
#(
    parameter int PC_WIDTH  = PC_WIDTH_DEF,
    parameter int OFF_WIDTH = OFF_WIDTH_DEF,
    parameter int DEPTH     = DEPTH_DEF
) (
    input  logic           clk,
    input  logic           reset,
    pc_sequencer_if.slave  bus
);
    localparam int DW = $clog2(DEPTH) + 1;

    logic [PC_WIDTH-1:0]        pc_q, pc_d;
    logic [PC_WIDTH-1:0]        pc_inc;
    logic [PC_WIDTH-1:0]        pc_rel;
    logic [PC_WIDTH-1:0]        ret_addr;
    logic signed [PC_WIDTH-1:0] off_dec;
    logic                       ovf_q, ovf_d;
    logic                       unf_q, unf_d;
    logic                       push, pop, full, empty;
    logic [DW-1:0]              depth;

    assign pc_inc  = pc_q + PC_WIDTH'(1);
    assign off_dec = PC_WIDTH'(sm_decode(32'(bus.offset), OFF_WIDTH));
    assign pc_rel  = pc_q + $unsigned(off_dec);

    // The return address pushed is pc_inc, i.e. the instruction after the call.
    return_stack #(
        .WIDTH (PC_WIDTH),
        .DEPTH (DEPTH)
    ) u_stack (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (pc_inc),
        .dout  (ret_addr),
        .depth (depth),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        pc_d  = pc_q;
        ovf_d = ovf_q & ~bus.clear_err;
        unf_d = unf_q & ~bus.clear_err;
        push  = 1'b0;
        pop   = 1'b0;
        if (!bus.hold) begin
            if (bus.s_ret) begin
                if (!empty) begin
                    pop  = 1'b1;
                    pc_d = ret_addr;
                end else begin
                    unf_d = 1'b1;
                    pc_d  = pc_inc;
                end
            end else if (bus.s_call) begin
                pc_d = bus.target;
                if (!full) begin
                    push = 1'b1;
                end else begin
                    ovf_d = 1'b1;
                end
            end else if (!bus.s_inc) begin
                pc_d = bus.target;
            end else if (bus.s_rel) begin
                pc_d = pc_rel;
            end else begin
                pc_d = pc_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q  <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign bus.pc_out    = pc_q;
    assign bus.depth_out = depth;
    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the single-cycle microcontroller. It replaces the fixed PC register, the incrementer, the relative-jump adder and the single return-address register with one block. The block adds a return-address stack of configurable depth, so nested subroutine calls work, and it reports stack errors through sticky flags. It drives the program-memory address directly.

## Interface
Parameters:
- PC_WIDTH, 10: program-counter width. Program space is 2^PC_WIDTH words.
- OFF_WIDTH, 10: relative-offset field width, sign-magnitude. Bit OFF_WIDTH-1 is the sign; the rest is the magnitude. Legal range 2..PC_WIDTH.
- DEPTH, 8: return-stack entries. Power of two, ≥2.

Ports:
- clk, in, 1: system clock, all state on the rising edge.
- reset, in, 1: synchronous, active-high.
- hold, in, 1: freeze PC and stack this cycle.
- s_inc, in, 1: 1 = sequential or relative; 0 = absolute jump to target.
- s_rel, in, 1: with s_inc=1, add the decoded offset instead of 1.
- s_call, in, 1: push pc_out+1 and jump to target.
- s_ret, in, 1: pop the return stack into the PC.
- clear_err, in, 1: clear the sticky error flags.
- target, in, PC_WIDTH: absolute jump or call destination (instruction field).
- offset, in, OFF_WIDTH: sign-magnitude relative displacement.
- pc_out, out, PC_WIDTH: current PC, registered.
- depth_out, out, $clog2(DEPTH)+1: number of valid stack entries.
- overflow, out, 1: sticky; set when a call is made with the stack full.
- underflow, out, 1: sticky; set when a return is made with the stack empty.

## Operation
Control priority per cycle: reset > hold > s_ret > s_call > s_inc/s_rel. Lower-priority controls asserted together with a higher one are ignored.

- **reset:** pc_out=0, depth_out=0, overflow=0, underflow=0. Stack RAM contents are not cleared and are unobservable.
- **hold:** pc_out, stack and depth are unchanged. clear_err still acts.
- **s_ret, depth>0:** pc_out ← top entry; depth decrements.
- **s_ret, depth=0:** underflow ← 1; pc_out ← pc_out+1.
- **s_call, depth<DEPTH:** push (pc_out+1) mod 2^PC_WIDTH; depth increments; pc_out ← target.
- **s_call, depth=DEPTH:** overflow ← 1; stack unchanged (the new return address is discarded); pc_out ← target.
- **s_inc=0:** pc_out ← target.
- **s_inc=1, s_rel=0:** pc_out ← pc_out+1.
- **s_inc=1, s_rel=1:** decode the offset to two's complement: negate the magnitude if the sign bit is set, then sign-extend to PC_WIDTH. pc_out ← pc_out + decoded offset.
- **Offset corner case:** negative zero (sign=1, magnitude=0) equals +0, so the PC stays put (self-loop).
- **Arithmetic:** all PC arithmetic is modulo 2^PC_WIDTH. 2^PC_WIDTH-1 + 1 wraps to 0.
- **Error flags:** clear_err zeroes both flags. If clear_err coincides with a new error event, the event wins and the flag reads 1.
- **Stack organisation:** LIFO with a write pointer equal to depth. The top entry is at depth-1.

## Timing
- pc_out, depth_out and the flags are registered. The effect of the controls sampled at edge N is visible after edge N.
- Return address is computed from pc_out as of the call cycle, so the callee's return resumes at the instruction following the call.
- Combinational path: pc_out → adder/mux → next-PC. No combinational path from any input to any output.
- Stack read is asynchronous from a register array, so a return completes in one cycle.
- Back-to-back call/return in consecutive cycles is supported at full rate.
- Reset asserted in the middle of a call sequence fully empties the stack on the next edge.

## Structure
- Shared package microc_pkg holds:
  - default PC_WIDTH and OFF_WIDTH;
  - the sign-magnitude decode function, which is also used by the ALU immediate path.
- Sub-module return_stack (parameters WIDTH, DEPTH):
  - ports: push, pop, din, dout, depth, full, empty;
  - owns the register array and pointer.
- pc_sequencer contains the next-PC mux, the adders, the error flags and the priority logic.

## Test plan
- **Reset and increment:** assert reset, then s_inc=1 for 3 cycles → pc_out 0,1,2,3; depth_out=0; flags 0.
- **Relative jumps:** at PC=20, s_rel with offset sign=1, magnitude=5 → pc_out=15. Then offset magnitude 3, positive → 18. Then negative zero → 18.
- **Wrap-around:**
  - at PC=1023, increment → 0;
  - at PC=2, relative −4 → 1022.
- **Nested calls:** call target 100 at PC=10, then call target 200 at PC=101, then return → 102, then return → 11. depth_out sequence 1,2,1,0.
- **Overflow:** DEPTH=8; nine calls to target 50 → overflow=1 after the ninth, depth_out=8, pc_out=50. Eight returns then unwind to the first eight return addresses.
- **Underflow and errors:**
  - return at depth 0 from PC=7 → pc_out=8, underflow=1;
  - hold for 2 cycles → pc_out stays 8;
  - clear_err → underflow=0;
  - clear_err together with another empty return → underflow stays 1.
